// File: rtl/mini_mips_pkg.sv
// Shared MiniMIPS definitions: default widths, fetch timeout and the fetch FSM encoding.
package mini_mips_pkg;

   localparam int ADDR_W_DEF   = 32;
   localparam int INSTR_W_DEF  = 16;
   localparam int MAX_WAIT_DEF = 255;

   localparam int NUM_ENT = 2;
   localparam int ENT_CUR = 0;
   localparam int ENT_PF  = 1;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_DEMAND,
      FS_PREFETCH,
      FS_ERROR
   } fetch_state_e;

endpackage

// File: rtl/fetch_entry.sv
// One fetch buffer slot: address/data/valid register with load, clear and a PC match output.
module fetch_entry #(
   parameter int AW = 32,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_i,
   input  logic          clr_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   input  logic [AW-1:0] match_addr_i,
   output logic          vld_o,
   output logic [AW-1:0] addr_o,
   output logic [DW-1:0] data_o,
   output logic          match_o
);

   logic          vld_q, vld_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] data_q, data_d;

   // A load beats a clear so an entry can be refilled on the edge it is consumed.
   always_comb begin
      vld_d  = vld_q;
      addr_d = addr_q;
      data_d = data_q;
      if (load_i) begin
         vld_d  = 1'b1;
         addr_d = addr_i;
         data_d = data_i;
      end else if (clr_i) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign vld_o   = vld_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign match_o = vld_q && (addr_q == match_addr_i);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the MiniMIPS core: a current and a sequential prefetch entry
// filled from a variable-latency memory over a req/ack handshake, with a timeout.
module instr_fetch_unit
   import mini_mips_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int INSTR_W  = INSTR_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               advance,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic               fetch_err,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   fetch_state_e        state_q;
   logic                mem_req_q;
   logic                fetch_err_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [WAIT_W-1:0]   wait_cnt_q;

   logic                ent_load    [NUM_ENT];
   logic                ent_clr     [NUM_ENT];
   logic [ADDR_W-1:0]   ent_addr_in [NUM_ENT];
   logic [INSTR_W-1:0]  ent_data_in [NUM_ENT];
   logic                ent_vld     [NUM_ENT];
   logic [ADDR_W-1:0]   ent_addr    [NUM_ENT];
   logic [INSTR_W-1:0]  ent_data    [NUM_ENT];
   logic                ent_match   [NUM_ENT];

   generate
      for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_ent
         fetch_entry #(
            .AW (ADDR_W),
            .DW (INSTR_W)
         ) u_entry (
            .clk          (clk),
            .rst_n        (rst_n),
            .load_i       (ent_load[gi]),
            .clr_i        (ent_clr[gi]),
            .addr_i       (ent_addr_in[gi]),
            .data_i       (ent_data_in[gi]),
            .match_addr_i (pc),
            .vld_o        (ent_vld[gi]),
            .addr_o       (ent_addr[gi]),
            .data_o       (ent_data[gi]),
            .match_o      (ent_match[gi])
         );
      end
   endgenerate

   logic [ADDR_W-1:0] cur_next;
   logic ack_acc, hit, pf_hit, pf_seq, consume;
   logic dmd_load, pf_ack, pf_to_cur, pf_keep, promote, miss, pf_go;

   assign cur_next = ent_addr[ENT_CUR] + ADDR_W'(1);
   assign ack_acc  = mem_req_q && mem_ack;
   assign hit      = ent_match[ENT_CUR] && (state_q != FS_ERROR);
   assign pf_hit   = ent_match[ENT_PF];
   assign pf_seq   = ent_vld[ENT_PF] && (ent_addr[ENT_PF] == cur_next);
   assign consume  = advance && hit;
   assign dmd_load = ack_acc && (state_q == FS_DEMAND);
   assign pf_ack   = ack_acc && (state_q == FS_PREFETCH);

   // A prefetch that returns exactly when the core wants it goes straight into cur,
   // saving the promotion cycle; one orphaned by a branch elsewhere is dropped.
   assign pf_to_cur = pf_ack && ((consume && (mem_addr_q == cur_next)) ||
                                 (!hit && (mem_addr_q == pc)));
   assign pf_keep   = pf_ack && hit && !pf_to_cur;
   assign promote   = (state_q != FS_ERROR) && !dmd_load &&
                      ((consume && pf_seq) || (!hit && pf_hit));
   assign miss      = !hit && !pf_hit;
   assign pf_go     = ent_vld[ENT_CUR] && !ent_vld[ENT_PF];

   assign ent_load[ENT_CUR]    = dmd_load || pf_to_cur || promote;
   assign ent_clr[ENT_CUR]     = consume;
   assign ent_addr_in[ENT_CUR] = promote ? ent_addr[ENT_PF] : mem_addr_q;
   assign ent_data_in[ENT_CUR] = promote ? ent_data[ENT_PF] : mem_rdata;

   assign ent_load[ENT_PF]     = pf_keep;
   assign ent_clr[ENT_PF]      = promote;
   assign ent_addr_in[ENT_PF]  = mem_addr_q;
   assign ent_data_in[ENT_PF]  = mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FS_IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         wait_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            FS_IDLE: begin
               if (miss) begin
                  state_q    <= FS_DEMAND;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= pc;
                  wait_cnt_q <= '0;
               end else if (pf_go) begin
                  state_q    <= FS_PREFETCH;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= cur_next;
                  wait_cnt_q <= '0;
               end
            end
            FS_DEMAND, FS_PREFETCH: begin
               // Requests run to completion; a branch just waits for the ack.
               if (ack_acc) begin
                  state_q   <= FS_IDLE;
                  mem_req_q <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                  if (wait_cnt_q == WAIT_LAST) begin
                     state_q     <= FS_ERROR;
                     mem_req_q   <= 1'b0;
                     fetch_err_q <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign instr_valid = hit;
   assign instruction = hit ? ent_data[ENT_CUR] : '0;
   assign fetch_err   = fetch_err_q;
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-programmable memory responder, a small core
// model walking a PC list, and a scoreboard of expected instruction words.
module tb_instr_fetch_unit;

   localparam int AW = 32;
   localparam int IW = 16;
   localparam int MW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] pc;
   logic          advance;
   logic [IW-1:0] instruction;
   logic          instr_valid;
   logic          fetch_err;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [IW-1:0] mem_rdata;

   int            n_checks = 0;
   int            n_pass   = 0;
   logic [IW-1:0] mem [64];
   logic [IW-1:0] exp_q [$];
   int            req_log [$];
   int            pc_list [$];
   int            mem_lat  = 0;
   bit            mem_hold = 1'b0;
   int            lat_cnt  = 0;
   bit            prev_req = 1'b0;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .MAX_WAIT (MW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .advance     (advance),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .fetch_err   (fetch_err),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_sb(input string tag);
      if (exp_q.size() == 0) check_eq({tag, "_sb_underflow"}, exp_q.size(), 1);
      else check_eq(tag, instruction, exp_q.pop_front());
   endtask

   task automatic set_pc(input int v);
      pc = AW'(v);
      exp_q.push_back(mem[v[5:0]]);
   endtask

   // Memory: ack after mem_lat cycles of mem_req, driven mid-cycle.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_req && !prev_req) req_log.push_back(int'(mem_addr));
         prev_req = mem_req;
         if (mem_req && !mem_hold && lat_cnt >= mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr[5:0]];
            lat_cnt   = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            lat_cnt   = mem_req ? lat_cnt + 1 : 0;
         end
      end
   end

   task automatic do_reset(input bit chk);
      rst_n   = 1'b0;
      advance = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      if (chk) begin
         check_eq("rst_req", mem_req, 0);
         check_eq("rst_addr", mem_addr, 0);
         check_eq("rst_vld", instr_valid, 0);
         check_eq("rst_instr", instruction, 0);
         check_eq("rst_err", fetch_err, 0);
      end
      #3;
      rst_n = 1'b1;
   endtask

   // Core model: present pc_list in order, advancing on every valid cycle.
   task automatic run_core(input bit adv_last, input bit chk_gap, input int budget);
      int idx    = 0;
      int cyc    = 0;
      int last_t = -1;
      int n      = pc_list.size();
      set_pc(pc_list[0]);
      while (idx < n && cyc < budget) begin
         @(posedge clk);
         #1;
         cyc++;
         if (advance) begin
            advance = 1'b0;
            idx++;
            if (idx < n) set_pc(pc_list[idx]);
         end
         #1;
         if (idx < n && instr_valid) begin
            $display("deliver pc=%0d instr=%h cycle=%0d", pc, instruction, cyc);
            check_sb("instr");
            if (chk_gap && last_t >= 0) check_eq("seq_gap", cyc - last_t, 2);
            last_t = cyc;
            if (idx == n - 1 && !adv_last) idx = n;
            else advance = 1'b1;
         end
      end
      advance = 1'b0;
      check_eq("core_done", idx, n);
   endtask

   task automatic wait_req(input string tag);
      bit found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(posedge clk);
         #1;
         if (mem_req) found = 1'b1;
      end
      check_eq(tag, found, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      pc      = '0;
      advance = 1'b0;
      for (int k = 0; k < 64; k++) mem[k] = 16'hA000 + 16'(k);
      mem[0] = 16'h1234;

      // Reset state and first-fetch latency with L = 0
      do_reset(1'b1);
      set_pc(0);
      @(posedge clk);
      #1;
      check_eq("t1_req_c1", mem_req, 1);
      check_eq("t1_addr_c1", mem_addr, 0);
      check_eq("t1_vld_c1", instr_valid, 0);
      @(posedge clk);
      #1;
      check_eq("t1_vld_c2", instr_valid, 1);
      check_sb("t1_instr");

      // Sequential run 0..7, L = 0
      mem[0] = 16'hA000;
      do_reset(1'b0);
      req_log.delete();
      pc_list.delete();
      for (int k = 0; k < 8; k++) pc_list.push_back(k);
      run_core(1'b1, 1'b1, 80);
      check_eq("t2_nreq", req_log.size() >= 8, 1);
      for (int k = 0; k < 8 && k < req_log.size(); k++) check_eq("t2_req_addr", req_log[k], k);

      // Branch 4 -> 20 while the prefetch of 5 is in flight, L = 3
      mem_lat = 3;
      do_reset(1'b0);
      req_log.delete();
      pc_list.delete();
      for (int k = 0; k < 5; k++) pc_list.push_back(k);
      run_core(1'b1, 1'b0, 120);
      check_eq("t3_pf_pending", mem_req, 1);
      check_eq("t3_pf_addr", mem_addr, 5);
      pc_list.delete();
      pc_list.push_back(20);
      run_core(1'b0, 1'b0, 40);
      check_eq("t3_req_pf5", req_log[req_log.size() - 2], 5);
      check_eq("t3_req_20", req_log[req_log.size() - 1], 20);

      // Branch into the prefetched word, L = 0
      mem_lat = 0;
      do_reset(1'b0);
      req_log.delete();
      pc_list.delete();
      pc_list.push_back(4);
      run_core(1'b0, 1'b0, 20);
      repeat (6) @(posedge clk);
      #1;
      check_eq("t4_nreq", req_log.size(), 2);
      check_eq("t4_idle_req", mem_req, 0);
      set_pc(5);
      #1;
      check_eq("t4_vld_pre", instr_valid, 0);
      @(posedge clk);
      #2;
      check_eq("t4_vld", instr_valid, 1);
      check_sb("t4_instr");
      check_eq("t4_no_req", mem_req, 0);
      check_eq("t4_nreq_after", req_log.size(), 2);

      // Timeout: ack never arrives
      mem_hold = 1'b1;
      do_reset(1'b0);
      pc = '0;
      wait_req("t5_req_rise");
      for (int k = 1; k <= MW; k++) begin
         @(posedge clk);
         #1;
         if (k == MW - 1) check_eq("t5_err_early", fetch_err, 0);
      end
      check_eq("t5_err", fetch_err, 1);
      check_eq("t5_req_drop", mem_req, 0);
      check_eq("t5_vld", instr_valid, 0);
      mem_hold = 1'b0;
      pc = AW'(3);
      repeat (5) @(posedge clk);
      #1;
      check_eq("t5_err_sticky", fetch_err, 1);
      check_eq("t5_req_sticky", mem_req, 0);
      check_eq("t5_vld_sticky", instr_valid, 0);
      check_eq("t5_instr_zero", instruction, 0);

      // Async reset in the middle of a wait, L = 5
      mem_lat = 5;
      do_reset(1'b0);
      req_log.delete();
      pc = '0;
      wait_req("t6_req_rise");
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("t6_req_async", mem_req, 0);
      check_eq("t6_addr_async", mem_addr, 0);
      check_eq("t6_vld_async", instr_valid, 0);
      check_eq("t6_err_async", fetch_err, 0);
      pc = AW'(12);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      exp_q.delete();
      pc_list.delete();
      pc_list.push_back(12);
      run_core(1'b0, 1'b0, 40);
      check_eq("t6_req_abandoned", req_log[0], 0);
      check_eq("t6_req_restart", req_log[req_log.size() - 1], 12);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the MiniMIPS single-cycle core. It turns the core's word-indexed program counter into a 16-bit instruction word, sourcing it from a variable-latency instruction memory over a req/ack handshake. It holds one current entry and one sequential prefetch entry, and raises `instr_valid` only when the held instruction matches the core's PC. The core advances its PC only while `instr_valid` is high.

## Interface
- `ADDR_W`, 32: PC and memory address width, in instruction words.
- `INSTR_W`, 16: instruction width.
- `MAX_WAIT`, 255: maximum cycles `mem_req` may wait for `mem_ack` before a fetch error.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc`  in  ADDR_W: core program counter; increments by 1 per sequential instruction.
- `advance`  in  1: core consumes the presented instruction this cycle; `pc` changes at the next edge.
- `instruction`  out  INSTR_W: instruction for `pc`; all zeros when `instr_valid` = 0.
- `instr_valid`  out  1: `instruction` belongs to the current `pc`.
- `fetch_err`  out  1: sticky timeout flag.
- `mem_req`  out  1: memory read request; held until acknowledged.
- `mem_addr`  out  ADDR_W: read address; stable while `mem_req` = 1.
- `mem_ack`  in  1: read complete; `mem_rdata` is valid this cycle.
- `mem_rdata`  in  INSTR_W: read data.

## Operation
- Entries:
  - current: `cur_addr`, `cur_data`, `cur_vld`.
  - prefetch: `pf_addr`, `pf_data`, `pf_vld`.
- Hit and output: `instr_valid` = `cur_vld && cur_addr == pc`. This is combinational from registers and `pc`.
- Consume: an edge where `advance && instr_valid` holds:
  - If `pf_vld` and `pf_addr == cur_addr+1`, pf is promoted to cur and `pf_vld` clears.
  - Otherwise `cur_vld` clears.
  - `advance` while `instr_valid` = 0 is ignored.
- Miss: `instr_valid` = 0 with `pc` ≠ `pf_addr` (or `pf_vld` = 0) is a demand miss.
  - If `pf_vld && pf_addr == pc`, pf is promoted to cur instead; this covers a branch into the prefetched word.
- FSM states: IDLE, DEMAND, PREFETCH, ERROR.
  - IDLE -> DEMAND on a demand miss. Latch `mem_addr` = `pc`.
  - IDLE -> PREFETCH when cur is valid and `pf_vld` = 0. Latch `mem_addr` = `cur_addr+1` (mod 2^ADDR_W).
  - A demand miss has priority over a prefetch.
  - DEMAND, on ack: load cur = {`mem_addr`, `mem_rdata`}, then -> IDLE. If `pc` changed during the wait, the loaded entry simply misses, and IDLE refetches.
  - PREFETCH, on ack: load pf, then -> IDLE. The pf result is discarded if cur was invalidated by a branch and `mem_addr` ≠ `pc`.
  - In-flight requests are never cancelled. A branch during PREFETCH waits for the ack.
  - A wait counter counts cycles with `mem_req` = 1 and no ack. When it reaches MAX_WAIT: go to ERROR, set `fetch_err`, drop `mem_req`.
  - ERROR is terminal until reset. In ERROR, `instr_valid` = 0.
- `mem_ack` while `mem_req` = 0 is ignored.
- Reset values:
  - state IDLE.
  - `cur_vld`, `pf_vld`, `mem_req`, `instr_valid`, `fetch_err` all 0.
  - `mem_addr`, `instruction`, and the wait counter all 0.
  - Reset asserted mid-transaction drops `mem_req` immediately. The memory must tolerate an abandoned request.

## Timing
- `mem_req` and `mem_addr` are registered. A miss detected in cycle t drives `mem_req` from cycle t+1.
- Ack latency L ≥ 0: ack may arrive in the same cycle `mem_req` first rises.
- Ack in cycle t+1+L gives `instr_valid` = 1 in cycle t+2+L.
- Sequential code with L = 0 yields one instruction every 2 cycles:
  - The prefetch issues the cycle after cur loads.
  - Promotion on `advance` gives back-to-back hits when pf is already valid.
- `mem_addr` must not change while `mem_req` = 1.
- `fetch_err` rises exactly MAX_WAIT cycles after `mem_req` first rises without an ack.

## Structure
- Shared package `mini_mips_pkg` holds:
  - `INSTR_W` and `ADDR_W` defaults.
  - the fetch FSM state enum.
  - `MAX_WAIT` default.
- One sub-module, `fetch_entry`: the addr/data/valid register with load, clear and match output. It is instantiated for cur and pf.

## Test plan
- Reset, with `pc` = 0 and memory `[0]` = 16'h1234, L = 0: `mem_req` rises cycle 1, `instr_valid` = 1 with `instruction` = 16'h1234 in cycle 2.
- Sequential run, `pc` 0..7, memory `[i]` = 16'hA000+i, `advance` every valid cycle: every word is delivered in order, no address is requested twice, and `mem_addr` increments by 1.
- Branch during prefetch: `pc` jumps from 4 to 20 while the prefetch of 5 is pending with L = 3. The ack for 5 is accepted, then `mem_addr` = 20, and `instruction` = mem`[20]`. Word 5 is never presented.
- Branch into prefetch: cur = 4, pf = 5, `pc` jumps to 5 without `advance`. `instr_valid` = 1 the next cycle with no new `mem_req`.
- Timeout, with MAX_WAIT = 8 and `mem_ack` held 0: `fetch_err` = 1 exactly 8 cycles after `mem_req` rises, then `mem_req` = 0 and `instr_valid` = 0, persisting until reset.
- Async reset asserted mid-wait (L = 5): all outputs go to 0 immediately. After release, the fetch restarts at the current `pc`.
